key_press_detector: RTL and testbench

//  Consumes the camera pixel stream beside the piano-keyboard overlay and detects which on-screen

---
 rtl/key_press_detector.sv | 163 ++++++++++++++++
 tb/tb_key_press_detector.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_press_detector.sv
// key_press_detector: counts red-marker pixels per on-screen piano key over
// one video frame, thresholds the counts at frame end, debounces the result
// across frames and drives the pressed-key vector plus a lowest-note output.
// Optional feature macro: KEYDET_HYST_EN (pressed keys stay hit down to half
// the normal threshold).
module key_press_detector #(
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int R_MIN      = 10,
  parameter int GB_MAX     = 5,
  parameter int HIT_THRESH = 200,
  parameter int DEB_FRAMES = 3,
  parameter int CNT_W      = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [3:0]  cam_r,
  input  logic [3:0]  cam_g,
  input  logic [3:0]  cam_b,
  output logic [12:0] keys_pressed,
  output logic        note_valid,
  output logic [3:0]  note_idx,
  output logic        note_on
);

  localparam int NKEYS = 13;
  localparam logic [9:0] X_LAST   = 10'(H_ACT - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_ACT - 1);
  localparam logic [3:0] R_MIN_L  = 4'(R_MIN);
  localparam logic [3:0] GB_MAX_L = 4'(GB_MAX);
  localparam logic [3:0] DEB_L    = 4'(DEB_FRAMES);
  localparam logic [CNT_W-1:0] THR_FULL = CNT_W'(HIT_THRESH);
`ifdef KEYDET_HYST_EN
  localparam logic [CNT_W-1:0] THR_HALF = CNT_W'(HIT_THRESH >> 1);
`endif
  // Centre columns of the five black keys, left to right.
  localparam logic [9:0] BLACK_C [5] = '{10'd110, 10'd180, 10'd320, 10'd390, 10'd460};

  typedef enum logic [1:0] {WAIT, ACCUM, EVAL, DEB} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [NKEYS];
  logic [3:0]       deb [NKEYS];
  logic [NKEYS-1:0] hit;

  logic             last_px;
  logic             marker;
  logic             key_vld;
  logic [3:0]       key_sel;
  logic             count_en;
  logic [NKEYS-1:0] hit_next;
  logic [NKEYS-1:0] keys_next;
  logic [3:0]       deb_next [NKEYS];
  logic [3:0]       idx_next;
  logic             on_next;

  assign last_px  = de && (x == X_LAST) && (y == Y_LAST);
  assign marker   = (cam_r >= R_MIN_L) && (cam_g <= GB_MAX_L) && (cam_b <= GB_MAX_L);
  assign count_en = de && marker && key_vld;

  // Map the current pixel position to a key; black ranges override white in the black band.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    key_sel = '0;
    key_vld = 1'b0;
    if (y >= 10'd250 && y <= 10'd479 && x >= 10'd40 && x <= 10'd599) begin
      key_vld = 1'b1;
      for (int i = 1; i < 8; i++) begin
        if (x >= 10'(40 + 70 * i)) key_sel = 4'(i);
      end
    end
    if (y >= 10'd250 && y <= 10'd370) begin
      for (int j = 0; j < 5; j++) begin
        if (x >= BLACK_C[j] - 10'd24 && x <= BLACK_C[j] + 10'd23) begin
          key_vld = 1'b1;
          key_sel = 4'(8 + j);
        end
      end
    end
  end

  // Frame-end threshold per key (lower threshold for already-pressed keys when hysteresis is on).
  always_comb begin
    hit_next = '0;
    for (int k = 0; k < NKEYS; k++) begin
`ifdef KEYDET_HYST_EN
      hit_next[k] = keys_pressed[k] ? (cnt[k] >= THR_HALF) : (cnt[k] >= THR_FULL);
`else
      hit_next[k] = (cnt[k] >= THR_FULL);
`endif
    end
  end

  // Debounce step and the note outputs derived from the new key state.
  always_comb begin
    keys_next = keys_pressed;
    for (int k = 0; k < NKEYS; k++) begin
      deb_next[k] = 4'd0;
      if (hit[k] != keys_pressed[k]) begin
        if (deb[k] + 4'd1 == DEB_L) keys_next[k] = ~keys_pressed[k];
        else                         deb_next[k] = deb[k] + 4'd1;
      end
    end
    idx_next = '0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (keys_next[k]) idx_next = 4'(k);
    end
    on_next = (|keys_next) && (!note_valid || idx_next != note_idx);
  end

  // Frame FSM: sync to a frame end, accumulate, evaluate, debounce, repeat.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT;
      // NOTE: cnt/deb are small flop arrays, not RAM, so they are cleared with the rest of the state.
      for (int k = 0; k < NKEYS; k++) begin
        cnt[k] <= '0;
        deb[k] <= '0;
      end
      hit          <= '0;
      keys_pressed <= '0;
      note_valid   <= 1'b0;
      note_idx     <= '0;
      note_on      <= 1'b0;
    end else begin
      note_on <= 1'b0;
      case (state)
        WAIT: begin
          if (last_px) begin
            state <= ACCUM;
            for (int k = 0; k < NKEYS; k++) cnt[k] <= '0;
          end
        end
        ACCUM: begin
          for (int k = 0; k < NKEYS; k++) begin
            if (count_en && key_sel == 4'(k) && cnt[k] != {CNT_W{1'b1}})
              cnt[k] <= cnt[k] + 1'b1;
          end
          if (last_px) state <= EVAL;
        end
        EVAL: begin
          hit <= hit_next;
          for (int k = 0; k < NKEYS; k++) cnt[k] <= '0;
          state <= DEB;
        end
        DEB: begin
          for (int k = 0; k < NKEYS; k++) deb[k] <= deb_next[k];
          keys_pressed <= keys_next;
          note_valid   <= |keys_next;
          note_idx     <= idx_next;
          note_on      <= on_next;
          state        <= ACCUM;
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_detector.sv
// Self-checking bench for key_press_detector: a frame-level model computes the
// expected outputs from pixel rules, a compare process checks them every cycle,
// and literal checks pin the model at the key points of each scenario.
module tb_key_press_detector;

  localparam int HIT  = 200;
  localparam int DEBN = 3;
  localparam int SAT  = 8191;

  logic        clk = 1'b0;
  logic        reset;
  logic        de;
  logic [9:0]  x, y;
  logic [3:0]  cam_r, cam_g, cam_b;
  logic [12:0] keys_pressed;
  logic        note_valid;
  logic [3:0]  note_idx;
  logic        note_on;

  key_press_detector dut (
    .clk(clk), .reset(reset), .de(de), .x(x), .y(y),
    .cam_r(cam_r), .cam_g(cam_g), .cam_b(cam_b),
    .keys_pressed(keys_pressed), .note_valid(note_valid),
    .note_idx(note_idx), .note_on(note_on)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  bit chk_en = 0;

  // Model state
  int          m_cnt [13];
  int          m_deb [13];
  logic [12:0] m_keys;
  bit          m_sync;
  int          pend_dly;
  logic [12:0] pend_keys;
  logic        pend_valid, pend_on;
  logic [3:0]  pend_idx;
  logic [12:0] exp_keys;
  logic        exp_valid, exp_on;
  logic [3:0]  exp_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int key_of(input int px, input int py);
    int c [5] = '{110, 180, 320, 390, 460};
    if (py >= 250 && py <= 370)
      for (int j = 0; j < 5; j++)
        if (px >= c[j] - 24 && px <= c[j] + 23) return 8 + j;
    if (py >= 250 && py <= 479 && px >= 40 && px <= 599) return (px - 40) / 70;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 13; k++) begin m_cnt[k] = 0; m_deb[k] = 0; end
    m_keys = '0; m_sync = 0; pend_dly = 0;
    exp_keys = '0; exp_valid = 0; exp_idx = '0; exp_on = 0;
  endtask

  task automatic frame_end();
    logic [12:0] old_keys;
    int thr, lo;
    bit hitk;
    old_keys = m_keys;
    for (int k = 0; k < 13; k++) begin
      thr = HIT;
`ifdef KEYDET_HYST_EN
      if (old_keys[k]) thr = HIT / 2;
`endif
      hitk = (m_cnt[k] >= thr);
      if (hitk != old_keys[k]) begin
        m_deb[k]++;
        if (m_deb[k] == DEBN) begin m_keys[k] = ~m_keys[k]; m_deb[k] = 0; end
      end else m_deb[k] = 0;
      m_cnt[k] = 0;
    end
    lo = 0;
    for (int k = 12; k >= 0; k--) if (m_keys[k]) lo = k;
    pend_keys  = m_keys;
    pend_valid = (m_keys != 0);
    pend_idx   = 4'(lo);
    pend_on    = pend_valid && (old_keys == 0 || pend_idx != exp_idx);
    pend_dly   = 2;
  endtask

  task automatic model_sample(input logic d, input int px, input int py, input int r, input int g, input int b);
    bit last;
    int k;
    last = d && px == 639 && py == 479;
    if (!m_sync) begin
      if (last) begin
        m_sync = 1;
        for (int i = 0; i < 13; i++) m_cnt[i] = 0;
      end
      return;
    end
    k = key_of(px, py);
    if (d && k >= 0 && r >= 10 && g <= 5 && b <= 5 && m_cnt[k] < SAT) m_cnt[k]++;
    if (last) frame_end();
  endtask

  // One clock cycle of stimulus; the model follows the same sampled inputs.
  task automatic step(input logic d, input int px, input int py, input int r, input int g, input int b);
    de = d; x = 10'(px); y = 10'(py);
    cam_r = 4'(r); cam_g = 4'(g); cam_b = 4'(b);
    @(posedge clk); #1;
    exp_on = 0;
    if (reset) model_reset();
    else begin
      if (pend_dly > 0) begin
        pend_dly--;
        if (pend_dly == 0) begin
          exp_keys = pend_keys; exp_valid = pend_valid; exp_idx = pend_idx; exp_on = pend_on;
        end
      end
      model_sample(d, px, py, r, g, b);
    end
  endtask

  task automatic px_n(input int px, input int py, input int n,
                      input int r = 10, input int g = 0, input int b = 0);
    repeat (n) step(1'b1, px, py, r, g, b);
  endtask

  task automatic end_frame();
    step(1'b0, 5, 5, 0, 0, 0);
    step(1'b1, 639, 479, 0, 0, 0);
    repeat (5) step(1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic hold_1_8();
    px_n(130, 300, 250);
    px_n(130, 400, 250);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("outputs", 32'({keys_pressed, note_valid, note_idx, note_on}),
            32'({exp_keys, exp_valid, exp_idx, exp_on}));
      if (note_on) pulses++;
    end
  end

  initial begin
    reset = 1'b1; de = 0; x = '0; y = '0; cam_r = '0; cam_g = '0; cam_b = '0;
    model_reset();
    do_reset();
    chk_en = 1;
    check("reset_keys", 32'(keys_pressed), 32'h0);
    check("reset_note", 32'({note_valid, note_idx, note_on}), 32'h0);

    // Partial frame before sync is discarded.
    px_n(200, 400, 300);
    end_frame();

    // 199 px per frame never reaches the threshold.
    pulses = 0;
    repeat (5) begin px_n(200, 400, 199); end_frame(); end
    check("t2_keys", 32'(keys_pressed), 32'h0);
    check("t2_pulses", 32'(pulses), 32'd0);

    // 200 px per frame in white key 2; false frame ends must not trigger evaluation.
    pulses = 0;
    px_n(200, 400, 200);
    step(1'b0, 639, 479, 10, 0, 0);
    step(1'b1, 639, 500, 0, 0, 0);
    step(1'b1, 640, 479, 0, 0, 0);
    end_frame();
    px_n(200, 400, 200); end_frame();
    check("t1_keys_f2", 32'(keys_pressed), 32'h0);
    px_n(200, 400, 200); end_frame();
    check("t1_keys_f3", 32'(keys_pressed), 32'h0004);
    check("t1_idx", 32'({note_valid, note_idx}), 32'h12);
    check("t1_pulses", 32'(pulses), 32'd1);

    // 150 px per frame: released without hysteresis, held with it.
    pulses = 0;
    repeat (3) begin px_n(200, 400, 150); end_frame(); end
`ifdef KEYDET_HYST_EN
    check("t4_keys", 32'(keys_pressed), 32'h0004);
`else
    check("t4_keys", 32'(keys_pressed), 32'h0000);
`endif
    check("t4_pulses", 32'(pulses), 32'd0);

    // Black key 0 and white key 1 sharing column 130.
    repeat (3) begin hold_1_8(); end_frame(); end
    check("t3_keys", 32'(keys_pressed), 32'h0102);
    check("t3_idx", 32'({note_valid, note_idx}), 32'h11);

    // Key 5 alternating present/absent never survives debounce.
    for (int f = 0; f < 10; f++) begin
      hold_1_8();
      if (f % 2 == 0) px_n(400, 450, 250);
      end_frame();
    end
    check("t6_keys", 32'(keys_pressed), 32'h0102);

    // 8391 px saturates at 8191 (a wrapping counter would land on 199).
    repeat (3) begin hold_1_8(); px_n(560, 450, 8391); end_frame(); end
    check("sat_keys", 32'(keys_pressed), 32'h0182);

    // Region and colour boundaries.
    do_reset();
    end_frame();
    repeat (3) begin
      px_n(40, 250, 200);
      px_n(599, 479, 200);
      px_n(86, 370, 200);
      px_n(483, 250, 200);
      px_n(39, 300, 300);
      px_n(600, 300, 300);
      px_n(300, 249, 300);
      px_n(250, 450, 300, 9, 0, 0);
      px_n(250, 450, 300, 10, 6, 0);
      px_n(250, 450, 300, 10, 0, 6);
      repeat (300) step(1'b0, 250, 450, 10, 0, 0);
      px_n(250, 450, 200, 10, 5, 5);
      end_frame();
    end
    check("bound_keys", 32'(keys_pressed), 32'h1189);

    // Reset in the middle of a frame.
    px_n(60, 100, 50);
    px_n(60, 300, 150);
    do_reset();
    check("t5_reset", 32'({keys_pressed, note_valid, note_idx, note_on}), 32'h0);
    px_n(60, 300, 150);
    end_frame();
    check("t5_partial", 32'(keys_pressed), 32'h0);
    px_n(60, 300, 300); end_frame();
    px_n(60, 300, 300); end_frame();
    check("t5_f2", 32'(keys_pressed), 32'h0);
    px_n(60, 300, 300); end_frame();
    check("t5_f3", 32'(keys_pressed), 32'h0001);
    check("t5_note", 32'({note_valid, note_idx}), 32'h10);

    repeat (3) step(1'b0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
